alu_arbiter: RTL

//  Shares the single combinational ALU between two requesters: req 0 = execute

---
 rtl/alu_arbiter_pkg.sv | 36 +++
 rtl/alu_arbiter_if.sv | 44 ++++
 rtl/alu_arbiter_rr_arb2.sv | 29 ++
 rtl/alu_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared widths, requester IDs, lock FSM encoding and ALU opcode/flag layout
// for the two-requester ALU arbiter.
package alu_arbiter_pkg;

    localparam int DATA_W       = 8;
    localparam int OPER_W       = 4;
    localparam int FLAGS_W      = 4;
    localparam int LOCK_TMO_DEF = 15;
    localparam int CNT_W        = 4;
    localparam int NUM_REQ      = 2;

    localparam logic REQ_EXEC = 1'b0;
    localparam logic REQ_AGEN = 1'b1;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam logic [OPER_W-1:0] ALU_ADD = 4'h0;
    localparam logic [OPER_W-1:0] ALU_ADC = 4'h1;
    localparam logic [OPER_W-1:0] ALU_SUB = 4'h2;
    localparam logic [OPER_W-1:0] ALU_AND = 4'h4;
    localparam logic [OPER_W-1:0] ALU_XOR = 4'h6;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED0  = 2'd1,
        ST_LOCKED1  = 2'd2
    } lock_state_t;

    function automatic lock_state_t locked_state(input logic id);
        return id ? ST_LOCKED1 : ST_LOCKED0;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU-drive and response bundle between the requesters, the arbiter
// and the external combinational ALU.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
();

    logic [NUM_REQ-1:0]         rq_valid;
    logic [NUM_REQ-1:0]         rq_lock;
    logic [NUM_REQ*OPER_W-1:0]  rq_oper;
    logic [NUM_REQ*DATA_W-1:0]  rq_a;
    logic [NUM_REQ*DATA_W-1:0]  rq_b;
    logic [NUM_REQ*FLAGS_W-1:0] rq_flags;
    logic [NUM_REQ-1:0]         rq_ready;

    logic [OPER_W-1:0]          alu_oper;
    logic [DATA_W-1:0]          alu_a_in;
    logic [DATA_W-1:0]          alu_b_in;
    logic [FLAGS_W-1:0]         alu_proc_flags_in;
    logic [DATA_W-1:0]          alu_out;
    logic [FLAGS_W-1:0]         alu_proc_flags_out;

    logic                       rsp_valid;
    logic                       rsp_id;
    logic [DATA_W-1:0]          rsp_data;
    logic [FLAGS_W-1:0]         rsp_flags;
    logic                       lock_timeout;

    modport slave (
        input  rq_valid, rq_lock, rq_oper, rq_a, rq_b, rq_flags,
        input  alu_out, alu_proc_flags_out,
        output rq_ready,
        output alu_oper, alu_a_in, alu_b_in, alu_proc_flags_in,
        output rsp_valid, rsp_id, rsp_data, rsp_flags, lock_timeout
    );

    modport master (
        output rq_valid, rq_lock, rq_oper, rq_a, rq_b, rq_flags,
        output alu_out, alu_proc_flags_out,
        input  rq_ready,
        input  alu_oper, alu_a_in, alu_b_in, alu_proc_flags_in,
        input  rsp_valid, rsp_id, rsp_data, rsp_flags, lock_timeout
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; rr_prio names the requester that wins a tie and
// is reloaded by the lock FSM on every accept or forced lock release.
module alu_arbiter_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_prio,
    output logic [1:0] o_grant
);

    logic r_prio;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio <= 1'b0;
        end else if (i_upd) begin
            r_prio <= i_prio;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign o_grant[gi] = i_req[gi] & (~i_req[1 - gi] | (r_prio == 1'(gi)));
        end
    endgenerate

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between execute (req 0) and address generation
// (req 1): round-robin grant with carry-chain lock, op stage, tagged rsp stage.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int LOCK_TMO = LOCK_TMO_DEF
) (
    input  logic         master_clk,
    input  logic         reset_n,
    alu_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TMO - 1);

    lock_state_t        r_state;
    lock_state_t        w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_lock_timeout;
    logic               w_timeout_next;

    logic [1:0]         w_rr_grant;
    logic [1:0]         w_ready;
    logic               w_accept;
    logic               w_sel;
    logic               w_owner;
    logic               w_prio_upd;
    logic               w_prio_val;

    logic [OPER_W-1:0]  w_oper_arr  [NUM_REQ];
    logic [DATA_W-1:0]  w_a_arr     [NUM_REQ];
    logic [DATA_W-1:0]  w_b_arr     [NUM_REQ];
    logic [FLAGS_W-1:0] w_flags_arr [NUM_REQ];

    logic               r_op_valid;
    logic               r_op_id;
    logic [OPER_W-1:0]  r_alu_oper;
    logic [DATA_W-1:0]  r_alu_a;
    logic [DATA_W-1:0]  r_alu_b;
    logic [FLAGS_W-1:0] r_alu_flags;

    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_data;
    logic [FLAGS_W-1:0] r_rsp_flags;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_oper_arr[gi]  = bus.rq_oper[gi*OPER_W +: OPER_W];
            assign w_a_arr[gi]     = bus.rq_a[gi*DATA_W +: DATA_W];
            assign w_b_arr[gi]     = bus.rq_b[gi*DATA_W +: DATA_W];
            assign w_flags_arr[gi] = bus.rq_flags[gi*FLAGS_W +: FLAGS_W];
        end
    endgenerate

    alu_arbiter_rr_arb2 u_rr_arb2 (
        .i_clk   (master_clk),
        .i_rst_n (reset_n),
        .i_req   (bus.rq_valid),
        .i_upd   (w_prio_upd),
        .i_prio  (w_prio_val),
        .o_grant (w_rr_grant)
    );

    // Grants are suppressed while reset is held so nothing looks accepted.
    always_comb begin
        w_ready = 2'b00;
        if (reset_n) begin
            case (r_state)
                ST_LOCKED0: w_ready = {1'b0, bus.rq_valid[0]};
                ST_LOCKED1: w_ready = {bus.rq_valid[1], 1'b0};
                default:    w_ready = w_rr_grant;
            endcase
        end
    end

    assign w_accept = |w_ready;
    assign w_sel    = w_ready[1];
    assign w_owner  = (r_state == ST_LOCKED1);

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_UNLOCKED;
            r_cnt          <= '0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_lock_timeout <= w_timeout_next;
        end
    end

    // An owner accept in the same cycle as expiry takes precedence over timeout.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_timeout_next = 1'b0;
        w_prio_upd     = 1'b0;
        w_prio_val     = ~w_sel;
        case (r_state)
            ST_UNLOCKED: begin
                w_cnt_next = '0;
                if (w_accept) begin
                    w_prio_upd = 1'b1;
                    if (bus.rq_lock[w_sel]) begin
                        w_state_next = locked_state(w_sel);
                    end
                end
            end
            ST_LOCKED0, ST_LOCKED1: begin
                if (w_accept) begin
                    w_cnt_next = '0;
                    w_prio_upd = 1'b1;
                    if (!bus.rq_lock[w_owner]) begin
                        w_state_next = ST_UNLOCKED;
                    end
                end else if (r_cnt == TMO_LAST) begin
                    w_state_next   = ST_UNLOCKED;
                    w_cnt_next     = '0;
                    w_timeout_next = 1'b1;
                    w_prio_upd     = 1'b1;
                    w_prio_val     = ~w_owner;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_UNLOCKED;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_valid  <= 1'b0;
            r_op_id     <= 1'b0;
            r_alu_oper  <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_flags <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
        end else begin
            r_op_valid  <= w_accept;
            r_rsp_valid <= r_op_valid;
            if (w_accept) begin
                r_op_id     <= w_sel;
                r_alu_oper  <= w_oper_arr[w_sel];
                r_alu_a     <= w_a_arr[w_sel];
                r_alu_b     <= w_b_arr[w_sel];
                r_alu_flags <= w_flags_arr[w_sel];
            end
            if (r_op_valid) begin
                r_rsp_id    <= r_op_id;
                r_rsp_data  <= bus.alu_out;
                r_rsp_flags <= bus.alu_proc_flags_out;
            end
        end
    end

    assign bus.rq_ready          = w_ready;
    assign bus.alu_oper          = r_alu_oper;
    assign bus.alu_a_in          = r_alu_a;
    assign bus.alu_b_in          = r_alu_b;
    assign bus.alu_proc_flags_in = r_alu_flags;
    assign bus.rsp_valid         = r_rsp_valid;
    assign bus.rsp_id            = r_rsp_id;
    assign bus.rsp_data          = r_rsp_data;
    assign bus.rsp_flags         = r_rsp_flags;
    assign bus.lock_timeout      = r_lock_timeout;

endmodule
